// File: rtl/bp_me_network_pkg.sv
// Shared network definitions for the wormhole packet adapters: deserializer
// state encoding and width helpers used to size header fields and packets.
package bp_me_network_pkg;

    // Deserializer states: waiting for a head flit, collecting body flits,
    // or holding one complete packet for the consumer.
    typedef enum logic [1:0] {
        e_head = 2'd0,
        e_body = 2'd1,
        e_full = 2'd2
    } bp_me_deser_state_e;

    // Ceiling log2 that never returns zero, so one-value fields still get a bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of the header length field (number of flits after the head).
    function automatic int len_width(input int max_num_flit);
        return safe_clog2(max_num_flit);
    endfunction

    // Width of the flit index counter; it only ever reaches max_num_flit-1.
    function automatic int flit_count_width(input int max_num_flit);
        return safe_clog2(max_num_flit);
    endfunction

    // Full assembled packet width: header fields followed by the payload.
    function automatic int packet_width(input int x_width, input int y_width,
                                        input int max_num_flit, input int payload_width);
        return x_width + y_width + len_width(max_num_flit) + payload_width;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load the value one,
// which lets the head flit start the index at the first body slot.
module bsg_counter_clear_up
    import bp_me_network_pkg::*;
#(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    // Count register: clear has priority, optionally combined with an increment.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= up_i ? width_p'(1) : '0;
        end else if (up_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_me_wormhole_packet_deserializer.sv
// Reassembles one wormhole packet from the router flit stream: the head flit
// carries x/y/len on its LSBs, flits are packed LSB-first into a buffer, and
// the finished packet is held under a valid/ready handshake.
module bp_me_wormhole_packet_deserializer
    import bp_me_network_pkg::*;
#(
    parameter  int flit_width_p        = 16,
    parameter  int max_num_flit_p      = 4,
    parameter  int x_cord_width_p      = 2,
    parameter  int y_cord_width_p      = 2,
    parameter  int max_payload_width_p = 52,
    localparam int len_width_lp        = len_width(max_num_flit_p),
    localparam int packet_width_lp     = packet_width(x_cord_width_p, y_cord_width_p,
                                                      max_num_flit_p, max_payload_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [flit_width_p-1:0]        data_i,
    input  logic                           v_i,
    output logic                           ready_o,
    output logic [packet_width_lp-1:0]     data_o,
    output logic [max_payload_width_p-1:0] payload_o,
    output logic                           v_o,
    input  logic                           ready_i,
    output logic                           len_error_o
);

    localparam int hdr_len_lsb_lp = x_cord_width_p + y_cord_width_p;
    localparam int count_width_lp = flit_count_width(max_num_flit_p);
    localparam logic [len_width_lp-1:0] max_len_lp = len_width_lp'(max_num_flit_p - 1);

    bp_me_deser_state_e state_r, state_n;

    logic [len_width_lp-1:0]   len_r;
    logic [len_width_lp-1:0]   head_len;
    logic [len_width_lp-1:0]   head_len_clamped;
    logic                      head_len_bad;
    logic [count_width_lp-1:0] count;

    logic head_accept;
    logic body_accept;
    logic last_body;
    logic drain;
    logic count_clear;
    logic count_up;

    assign head_len = data_i[hdr_len_lsb_lp +: len_width_lp];

    // Only a length field wide enough to exceed the flit limit can be malformed.
    if ((1 << len_width_lp) > max_num_flit_p) begin : g_len_check
        assign head_len_bad = (head_len > max_len_lp);
    end else begin : g_len_fits
        assign head_len_bad = 1'b0;
    end

    assign head_len_clamped = head_len_bad ? max_len_lp : head_len;

    assign head_accept = (state_r == e_head) && v_i;
    assign body_accept = (state_r == e_body) && v_i;
    assign last_body   = body_accept && (count == len_r);
    assign drain       = (state_r == e_full) && ready_i;

    // Malformed heads are flagged on the cycle they are taken; reset masks it.
    assign len_error_o = head_accept && head_len_bad && !reset_i;

    // State register; an async reset drops any partially collected packet.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_head;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and handshake outputs, both derived from the registered state.
    always_comb begin
        state_n = state_r;
        v_o     = 1'b0;
        ready_o = 1'b1;
        case (state_r)
            e_head: begin
                if (v_i) begin
                    state_n = (head_len_clamped == '0) ? e_full : e_body;
                end
            end
            e_body: begin
                if (v_i && (count == len_r)) begin
                    state_n = e_full;
                end
            end
            e_full: begin
                v_o     = 1'b1;
                ready_o = 1'b0;
                if (ready_i) begin
                    state_n = e_head;
                end
            end
            default: begin
                state_n = e_head;
            end
        endcase
    end

    // Captured (clamped) body length of the packet currently being collected.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            len_r <= '0;
        end else if (head_accept) begin
            len_r <= head_len_clamped;
        end
    end

    // The flit index restarts at one on a multi-flit head and returns to zero
    // when the packet completes or leaves, so it never passes len_r.
    assign count_clear = head_accept || last_body || drain;
    assign count_up    = (head_accept && (head_len_clamped != '0)) ||
                         (body_accept && !last_body);

    bsg_counter_clear_up #(
        .width_p (count_width_lp)
    ) flit_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (count_clear),
        .up_i    (count_up),
        .count_o (count)
    );

    // One register per flit slot, keeping only the bits that land inside the
    // packet; a head clears every slot so short packets read back zero above.
    for (genvar s = 0; s < max_num_flit_p; s++) begin : g_slot
        localparam int lo_lp  = s * flit_width_p;
        localparam int rem_lp = packet_width_lp - lo_lp;
        localparam int w_lp   = (rem_lp >= flit_width_p) ? flit_width_p :
                                ((rem_lp > 0) ? rem_lp : 0);
        localparam logic [count_width_lp-1:0] idx_lp = count_width_lp'(s);

        if (w_lp > 0) begin : g_live
            logic [w_lp-1:0] slot_r;

            if (s == 0) begin : g_head_slot
                // The head slot is loaded only by the head flit itself.
                always_ff @(posedge clk_i or posedge reset_i) begin
                    if (reset_i) begin
                        slot_r <= '0;
                    end else if (head_accept) begin
                        slot_r <= data_i[w_lp-1:0];
                    end
                end
            end else begin : g_body_slot
                // Body slots are cleared by a new head and written at their index.
                always_ff @(posedge clk_i or posedge reset_i) begin
                    if (reset_i) begin
                        slot_r <= '0;
                    end else if (head_accept) begin
                        slot_r <= '0;
                    end else if (body_accept && (count == idx_lp)) begin
                        slot_r <= data_i[w_lp-1:0];
                    end
                end
            end

            assign data_o[lo_lp +: w_lp] = slot_r;
        end
    end

    if (packet_width_lp > max_num_flit_p * flit_width_p) begin : g_pad
        assign data_o[packet_width_lp-1:max_num_flit_p*flit_width_p] = '0;
    end

    assign payload_o = data_o[hdr_len_lsb_lp + len_width_lp +: max_payload_width_p];

endmodule
